// File: rtl/fsa_sprite.sv
// Sprite-drawing FSA: walks a SPRITE_W x SPRITE_H rectangle row-major and
// presents one pixel offset, colour and write strobe per cycle from a latched bitmap.
module fsa_sprite #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 4,
    parameter int XW = 3,
    parameter int YW = 2,
    parameter int CW = 3,
    parameter logic [CW-1:0] FG_COLOUR = 3'b101,
    parameter logic [CW-1:0] BG_COLOUR = 3'b000,
    parameter bit TRANSPARENT = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         draw_enable,
    input  logic                         erase,
    input  logic                         abort,
    input  logic [SPRITE_W*SPRITE_H-1:0] bitmap,
    output logic [XW-1:0]                add_x,
    output logic [YW-1:0]                add_y,
    output logic [CW-1:0]                colour,
    output logic                         write_en,
    output logic                         continue_draw,
    output logic                         busy
);

    localparam int N  = SPRITE_W * SPRITE_H;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [N-1:0]      bitmap_q;
    logic              erase_q;
    logic              last_x, last_y;
    logic [IW-1:0]     pix_idx;
    logic              pix;

    assign last_x  = (x_q == XW'(SPRITE_W - 1));
    assign last_y  = (y_q == YW'(SPRITE_H - 1));
    assign pix_idx = IW'(y_q) * IW'(SPRITE_W) + IW'(x_q);
    assign pix     = bitmap_q[pix_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (draw_enable) state_d = DRAW;
            DRAW: begin
                if (abort)                 state_d = IDLE;
                else if (last_x && last_y) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters wrap on the exact sprite bounds, so they never walk into
    // unused offsets when the sprite is narrower than the address field.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            bitmap_q <= '0;
            erase_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    x_q <= '0;
                    y_q <= '0;
                    if (draw_enable) begin
                        bitmap_q <= bitmap;
                        erase_q  <= erase;
                    end
                end
                DRAW: begin
                    if (abort || (last_x && last_y)) begin
                        x_q <= '0;
                        y_q <= '0;
                    end else if (last_x) begin
                        x_q <= '0;
                        y_q <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
                default: begin
                    x_q <= '0;
                    y_q <= '0;
                end
            endcase
        end
    end

    // Pure Moore decode: outputs depend only on registered state.
    always_comb begin
        add_x         = '0;
        add_y         = '0;
        colour        = '0;
        write_en      = 1'b0;
        continue_draw = 1'b0;
        busy          = 1'b0;
        case (state_q)
            DRAW: begin
                busy  = 1'b1;
                add_x = x_q;
                add_y = y_q;
                if (erase_q) begin
                    colour   = BG_COLOUR;
                    write_en = 1'b1;
                end else begin
                    colour   = pix ? FG_COLOUR : BG_COLOUR;
                    write_en = pix | ~TRANSPARENT;
                end
            end
            DONE: begin
                busy          = 1'b1;
                continue_draw = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fsa_sprite.sv
// Self-checking bench for fsa_sprite: default, transparent and legacy
// 5x1 alien-row instances driven with directed vectors.
module tb_fsa_sprite;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_de = 0, a_er = 0, a_ab = 0;
    logic [31:0] a_bm = '0;
    logic [2:0]  a_x, a_col;
    logic [1:0]  a_y;
    logic        a_we, a_cont, a_busy;

    logic        b_de = 0, b_er = 0, b_ab = 0;
    logic [31:0] b_bm = '0;
    logic [2:0]  b_x, b_col;
    logic [1:0]  b_y;
    logic        b_we, b_cont, b_busy;

    logic        c_de = 0, c_er = 0, c_ab = 0;
    logic [4:0]  c_bm = '0;
    logic [2:0]  c_x, c_col;
    logic [0:0]  c_y;
    logic        c_we, c_cont, c_busy;

    fsa_sprite dut_a (
        .clk(clk), .reset_n(reset_n), .draw_enable(a_de), .erase(a_er), .abort(a_ab),
        .bitmap(a_bm), .add_x(a_x), .add_y(a_y), .colour(a_col), .write_en(a_we),
        .continue_draw(a_cont), .busy(a_busy)
    );

    fsa_sprite #(.TRANSPARENT(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .draw_enable(b_de), .erase(b_er), .abort(b_ab),
        .bitmap(b_bm), .add_x(b_x), .add_y(b_y), .colour(b_col), .write_en(b_we),
        .continue_draw(b_cont), .busy(b_busy)
    );

    fsa_sprite #(.SPRITE_W(5), .SPRITE_H(1), .XW(3), .YW(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .draw_enable(c_de), .erase(c_er), .abort(c_ab),
        .bitmap(c_bm), .add_x(c_x), .add_y(c_y), .colour(c_col), .write_en(c_we),
        .continue_draw(c_cont), .busy(c_busy)
    );

    logic [10:0] a_out, b_out, c_out;
    assign a_out = {a_x, a_y, a_col, a_we, a_cont, a_busy};
    assign b_out = {b_x, b_y, b_col, b_we, b_cont, b_busy};
    assign c_out = {c_x, 1'b0, c_y, c_col, c_we, c_cont, c_busy};

    int checks = 0;
    int errors = 0;

    function automatic logic [10:0] pk(input int x, input int y, input int col,
                                       input bit we, input bit cont, input bit bsy);
        return {3'(x), 2'(y), 3'(col), we, cont, bsy};
    endfunction

    task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got {x,y,col,we,cont,busy}=%b required %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic       de;
        logic       ab;
        int         x;
        int         col;
        logic       we;
        logic       cont;
        logic       bsy;
    } vec_t;

    vec_t vecs[18];

    task automatic applyStimulus(input vec_t v, input int idx);
        c_de = v.de;
        c_ab = v.ab;
        @(negedge clk);
        checkOutput($sformatf("legacy_vec%0d", idx), c_out, pk(v.x, 0, v.col, v.we, v.cont, v.bsy));
    endtask

    initial begin
        // Legacy alien row, abort/start priority and abort-in-IDLE/DONE behaviour.
        vecs[0]  = '{1, 0, 0, 0, 1, 0, 1};
        vecs[1]  = '{0, 0, 1, 5, 1, 0, 1};
        vecs[2]  = '{0, 0, 2, 5, 1, 0, 1};
        vecs[3]  = '{0, 0, 3, 5, 1, 0, 1};
        vecs[4]  = '{0, 0, 4, 0, 1, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 1, 0, 1};
        vecs[12] = '{0, 0, 1, 5, 1, 0, 1};
        vecs[13] = '{0, 0, 2, 5, 1, 0, 1};
        vecs[14] = '{0, 0, 3, 5, 1, 0, 1};
        vecs[15] = '{0, 0, 4, 0, 1, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 1, 1};
        vecs[17] = '{0, 1, 0, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        checkOutput("reset_a", a_out, '0);
        checkOutput("reset_c", c_out, '0);
        reset_n = 1'b1;

        // Asynchronous reset mid-draw.
        a_bm = 32'hFFFF_FFFF;
        a_de = 1'b1;
        @(negedge clk);
        a_de = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_pix", a_out, pk(4, 0, 5, 1, 0, 1));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset", a_out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_after_reset%0d", i), a_out, '0);
        end

        // Full solid draw; bitmap and erase changes mid-draw must be ignored.
        a_de = 1'b1;
        @(negedge clk);
        a_de = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("solid_pix%0d", k), a_out, pk(k % 8, k / 8, 5, 1, 0, 1));
            if (k == 5) a_bm = 32'h0;
            if (k == 9) a_er = 1'b1;
            @(negedge clk);
        end
        checkOutput("solid_done", a_out, pk(0, 0, 0, 0, 1, 1));
        a_er = 1'b0;
        @(negedge clk);
        checkOutput("solid_idle", a_out, '0);

        // Erase mode: every pixel written with background colour.
        a_bm = 32'hFFFF_FFFF;
        a_er = 1'b1;
        a_de = 1'b1;
        @(negedge clk);
        a_de = 1'b0;
        a_er = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("erase_pix%0d", k), a_out, pk(k % 8, k / 8, 0, 1, 0, 1));
            if (k == 12) a_bm = 32'h0000_0F0F;
            @(negedge clk);
        end
        checkOutput("erase_done", a_out, pk(0, 0, 0, 0, 1, 1));
        @(negedge clk);

        // Abort while presenting (3,1): pixel still written, then IDLE with no pulse.
        a_bm = 32'hFFFF_FFFF;
        a_de = 1'b1;
        @(negedge clk);
        a_de = 1'b0;
        repeat (11) @(negedge clk);
        checkOutput("abort_pix", a_out, pk(3, 1, 5, 1, 0, 1));
        a_ab = 1'b1;
        @(negedge clk);
        a_ab = 1'b0;
        checkOutput("abort_idle", a_out, '0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_nopulse%0d", i), a_out, '0);
        end
        a_de = 1'b1;
        @(negedge clk);
        a_de = 1'b0;
        checkOutput("restart_pix0", a_out, pk(0, 0, 5, 1, 0, 1));
        @(negedge clk);
        checkOutput("restart_pix1", a_out, pk(1, 0, 5, 1, 0, 1));
        a_ab = 1'b1;
        @(negedge clk);
        a_ab = 1'b0;

        // draw_enable held high: one IDLE cycle between sprites.
        a_de = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("held_pix%0d", k), a_out, pk(k % 8, k / 8, 5, 1, 0, 1));
            @(negedge clk);
        end
        checkOutput("held_done", a_out, pk(0, 0, 0, 0, 1, 1));
        @(negedge clk);
        checkOutput("held_idle", a_out, '0);
        @(negedge clk);
        checkOutput("held_restart", a_out, pk(0, 0, 5, 1, 0, 1));
        a_de = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!a_busy) break;
            @(negedge clk);
        end
        checkOutput("held_drain", a_out, '0);

        // Transparent instance: only set bits are written.
        b_bm = 32'h0000_0081;
        b_de = 1'b1;
        @(negedge clk);
        b_de = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 0 || k == 7)
                checkOutput($sformatf("transp_pix%0d", k), b_out, pk(k % 8, k / 8, 5, 1, 0, 1));
            else
                checkOutput($sformatf("transp_pix%0d", k), b_out, pk(k % 8, k / 8, 0, 0, 0, 1));
            @(negedge clk);
        end
        checkOutput("transp_done", b_out, pk(0, 0, 0, 0, 1, 1));
        @(negedge clk);
        checkOutput("transp_idle", b_out, '0);

        // Legacy 5x1 alien row.
        c_bm = 5'b01110;
        for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsa_sprite.md
Name: fsa_sprite

Overview:
- Parametrised sprite-drawing FSA and the next generation of the fixed single-row alien drawer.
- Walks a SPRITE_W x SPRITE_H rectangle in row-major order and emits a pixel offset (add_x, add_y), a colour and a VGA write strobe each cycle. Pixel values come from a bitmap latched at start.
- Supports draw and erase modes, optional transparency and a synchronous abort.
- Sits between the top-level drawing FSA, which starts it and waits for continue_draw, and the VGA adapter.

Parameters:
- SPRITE_W, 8, sprite width in pixels (1..2^XW)
- SPRITE_H, 4, sprite height in pixels (1..2^YW)
- XW, 3, width of add_x
- YW, 2, width of add_y
- CW, 3, colour width
- FG_COLOUR, 3'b101, colour for set bitmap bits
- BG_COLOUR, 3'b000, colour for clear bits and for erase mode
- TRANSPARENT, 0, when 1 clear bits are not written in draw mode

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- draw_enable  input  1  start request, sampled only in IDLE
- erase  input  1  mode, latched with draw_enable: 1 = paint whole rectangle BG_COLOUR
- abort  input  1  synchronous cancel of an in-progress draw
- bitmap  input  SPRITE_W*SPRITE_H  pixel mask, bit index y*SPRITE_W+x, bit 0 = top-left; latched at start
- add_x  output  XW  column offset of current pixel
- add_y  output  YW  row offset of current pixel
- colour  output  CW  colour of current pixel
- write_en  output  1  VGA write strobe for current pixel
- continue_draw  output  1  one-cycle pulse: sprite complete, top FSA may draw next object
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low; on assertion the FSA goes to IDLE, counters clear, latched bitmap and erase clear.
- Reset values: every output is 0 (add_x, add_y, colour, write_en, continue_draw, busy).
- Outputs are a Moore decode of state plus registered counters and latches. No combinational path from any input to any output.
- States: IDLE, DRAW, DONE.
- IDLE:
  - All outputs 0.
  - draw_enable=1 at a clock edge: latch bitmap and erase, x=0, y=0, next state DRAW.
- DRAW:
  - Outputs: busy=1, add_x=x, add_y=y.
  - pix = bitmap_q[y*SPRITE_W+x].
  - erase_q=1: colour=BG_COLOUR, write_en=1.
  - erase_q=0: colour = pix ? FG_COLOUR : BG_COLOUR.
  - erase_q=0: write_en = pix | ~TRANSPARENT; when write_en=0, colour is still driven as above.
  - Each cycle x increments. At x=SPRITE_W-1, x wraps to 0 and y increments.
  - At (SPRITE_W-1, SPRITE_H-1) the next state is DONE.
  - Counters never exceed SPRITE_W-1 / SPRITE_H-1, including when SPRITE_W < 2^XW.
- DONE: exactly one cycle; continue_draw=1, busy=1, write_en=0, add_x=add_y=0, colour=0; next state IDLE unconditionally.
- Timing:
  - draw_enable sampled at edge T: first pixel (0,0) is presented in cycle T+1.
  - Last pixel is presented in cycle T+SPRITE_W*SPRITE_H.
  - continue_draw is high in cycle T+SPRITE_W*SPRITE_H+1.
- Restart: draw_enable held high restarts only after one IDLE cycle; back-to-back period is W*H+2 cycles.
- draw_enable, erase and bitmap changes during DRAW/DONE are ignored.
- abort=1 in DRAW: next state IDLE, counters clear, no continue_draw pulse. The pixel presented in the abort cycle is still emitted.
- abort in IDLE/DONE has no effect; DONE still completes its pulse.
- abort and draw_enable together in IDLE: the start wins (abort only acts in DRAW).
- reset_n asserted mid-DRAW: immediate IDLE, outputs 0 asynchronously, no continue_draw.
- SPRITE_W=1 or SPRITE_H=1 must work. W=5, H=1 with bitmap 5'b01110 and TRANSPARENT=0 reproduces the legacy alien row: colours 000,101,101,101,000 at add_x 0..4.

Test Plan:
- Reset: assert reset_n=0 mid-clock → all outputs 0 before the next edge; release, draw_enable=0 for 10 cycles → outputs stay 0.
- Defaults, bitmap=32'hFFFF_FFFF, erase=0, draw_enable pulse at T → cycles T+1..T+32 give (add_x,add_y) = (0,0),(1,0)..(7,0),(0,1)..(7,3), write_en=1, colour=101; continue_draw=1 only at T+33; busy=1 T+1..T+33.
- TRANSPARENT=1, bitmap=32'h0000_0081 → write_en=1 only at (0,0) and (7,0) with colour 101; other 30 cycles write_en=0; continue_draw at T+33.
- erase=1, bitmap=32'hFFFF_FFFF → 32 writes all colour 000; then change bitmap mid-draw → no effect on the sequence.
- abort=1 in the cycle presenting (3,1) → that pixel written, next cycle busy=0, no continue_draw ever; new draw_enable restarts at (0,0).
- draw_enable held high continuously → starts at T, continue_draw at T+33, IDLE at T+34, next (0,0) at T+35; SPRITE_W=5, SPRITE_H=1, bitmap=5'b01110 → legacy colour sequence 000,101,101,101,000 then continue_draw.
